// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared field defaults, screen widths and tracker state type
package breakout_pkg;

  localparam int DEFAULT_ROWS = 6;
  localparam int DEFAULT_COLS = 10;

  localparam int PIX_X_W = 10;
  localparam int PIX_Y_W = 9;

  localparam int SCORE_W = 16;

  typedef enum logic [1:0] {
    PLAYING      = 2'd0,
    VICTORY_WAIT = 2'd1,
    RESTORE      = 2'd2
  } tracker_state_t;

endpackage

// File: rtl/brick_pixel_lookup.sv
// rtl/brick_pixel_lookup.sv - maps the current pixel to a brick and registers brick_on
module brick_pixel_lookup
  import breakout_pkg::*;
#(
  parameter int ROWS         = DEFAULT_ROWS,
  parameter int COLS         = DEFAULT_COLS,
  parameter int BRICK_W_LOG2 = 6,
  parameter int BRICK_H_LOG2 = 4,
  parameter int FIELD_X0     = 0,
  parameter int FIELD_Y0     = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIX_X_W-1:0]   pixel_x,
  input  logic [PIX_Y_W-1:0]   pixel_y,
  input  logic [ROWS*COLS-1:0] alive,
  output logic                 brick_on
);

  localparam int IDX_W = $clog2(ROWS * COLS);

  // One extra bit on each difference acts as a borrow: set when the pixel is left of / above the field.
  logic [PIX_X_W:0]   dx;
  logic [PIX_Y_W:0]   dy;
  logic [PIX_X_W-1:0] col;
  logic [PIX_Y_W-1:0] row;
  logic [IDX_W-1:0]   idx;
  logic               lit;

  // Locate the brick under the pixel, range-check it and mask the gap column.
  always_comb begin
    dx  = {1'b0, pixel_x} - (PIX_X_W + 1)'(FIELD_X0);
    dy  = {1'b0, pixel_y} - (PIX_Y_W + 1)'(FIELD_Y0);
    col = dx[PIX_X_W-1:0] >> BRICK_W_LOG2;
    row = dy[PIX_Y_W-1:0] >> BRICK_H_LOG2;
    idx = IDX_W'(row * COLS + col);
    lit = 1'b0;
    if (!dx[PIX_X_W] && !dy[PIX_Y_W] && (col < COLS) && (row < ROWS) &&
        (dx[BRICK_W_LOG2-1:0] != '0)) begin
      lit = alive[idx];
    end
  end

  // Register the lookup result for the VGA mixer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brick_on <= 1'b0;
    end else begin
      brick_on <= lit;
    end
  end

endmodule

// File: rtl/brick_field_tracker.sv
// rtl/brick_field_tracker.sv - brick field owner and victory handshake initiator; optional BRICK_SCORE_EN adds a score output
module brick_field_tracker
  import breakout_pkg::*;
#(
  parameter int ROWS         = DEFAULT_ROWS,
  parameter int COLS         = DEFAULT_COLS,
  parameter int BRICK_W_LOG2 = 6,
  parameter int BRICK_H_LOG2 = 4,
  parameter int FIELD_X0     = 0,
  parameter int FIELD_Y0     = 48
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hit_valid,
  input  logic [2:0]                     hit_row,
  input  logic [3:0]                     hit_col,
  output logic                           hit_ack,
  input  logic                           victory_complete,
  output logic                           trigger_victory,
  output logic                           round_reset,
  output logic [$clog2(ROWS*COLS+1)-1:0] bricks_left,
  input  logic [PIX_X_W-1:0]             pixel_x,
  input  logic [PIX_Y_W-1:0]             pixel_y,
  output logic                           brick_on
`ifdef BRICK_SCORE_EN
  ,
  output logic [SCORE_W-1:0]             score
`endif
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(CELLS + 1);

  tracker_state_t   state, next_state;
  logic [CELLS-1:0] alive;
  logic [IDX_W-1:0] hit_idx;
  logic             in_range;
  logic             accept;
  logic             last_hit;

  // Qualify the hit report and choose the next FSM state; in_range is tested first so an aliased index never counts.
  always_comb begin
    hit_idx     = IDX_W'(hit_row * COLS + hit_col);
    in_range    = (hit_row < ROWS) && (hit_col < COLS);
    accept      = 1'b0;
    last_hit    = 1'b0;
    round_reset = 1'b0;
    next_state  = state;
    case (state)
      PLAYING: begin
        accept   = hit_valid && in_range && alive[hit_idx];
        last_hit = accept && (bricks_left == CNT_W'(1));
        if (last_hit) next_state = VICTORY_WAIT;
      end
      VICTORY_WAIT: begin
        if (victory_complete) next_state = RESTORE;
      end
      RESTORE: begin
        round_reset = 1'b1;
        next_state  = PLAYING;
      end
      default: next_state = PLAYING;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLAYING;
    end else begin
      state <= next_state;
    end
  end

  // Alive bits, live count and the one-cycle acknowledge/trigger pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive           <= '1;
      bricks_left     <= CNT_W'(CELLS);
      hit_ack         <= 1'b0;
      trigger_victory <= 1'b0;
    end else begin
      hit_ack         <= accept;
      trigger_victory <= last_hit;
      if (state == RESTORE) begin
        alive       <= '1;
        bricks_left <= CNT_W'(CELLS);
      end else if (accept) begin
        alive[hit_idx] <= 1'b0;
        bricks_left    <= bricks_left - CNT_W'(1);
      end
    end
  end

`ifdef BRICK_SCORE_EN
  logic [SCORE_W:0] score_sum;

  // Higher rows are worth more; the carry bit drives saturation.
  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W + 1)'(ROWS - hit_row);
  end

  // Score survives round restores and clears only on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= '0;
    end else if (accept) begin
      score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end
  end
`endif

  brick_pixel_lookup #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .BRICK_W_LOG2(BRICK_W_LOG2),
    .BRICK_H_LOG2(BRICK_H_LOG2),
    .FIELD_X0    (FIELD_X0),
    .FIELD_Y0    (FIELD_Y0)
  ) u_lookup (
    .clk     (clk),
    .reset   (reset),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .alive   (alive),
    .brick_on(brick_on)
  );

endmodule

// File: tb/tb_brick_field_tracker.sv
// tb/tb_brick_field_tracker.sv - table-driven and sequence checks for brick_field_tracker
module tb_brick_field_tracker;
  import breakout_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       hit_valid;
  logic [2:0] hit_row;
  logic [3:0] hit_col;
  logic       hit_ack;
  logic       victory_complete;
  logic       trigger_victory;
  logic       round_reset;
  logic [5:0] bricks_left;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       brick_on;
`ifdef BRICK_SCORE_EN
  logic [15:0] score;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  brick_field_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .hit_valid       (hit_valid),
    .hit_row         (hit_row),
    .hit_col         (hit_col),
    .hit_ack         (hit_ack),
    .victory_complete(victory_complete),
    .trigger_victory (trigger_victory),
    .round_reset     (round_reset),
    .bricks_left     (bricks_left),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .brick_on        (brick_on)
`ifdef BRICK_SCORE_EN
    ,
    .score           (score)
`endif
  );

  typedef struct {
    logic       hv;
    logic [2:0] r;
    logic [3:0] c;
    logic [9:0] px;
    logic [8:0] py;
    logic       ack;
    logic [5:0] bl;
    logic       on;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_field(input string tag, input int exp_hits);
    int  acks;
    int  trigs;
    logic trig_last;
    acks = 0;
    trigs = 0;
    trig_last = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 10; c++) begin
        hit_valid = 1'b1;
        hit_row   = 3'(r);
        hit_col   = 4'(c);
        step();
        if (hit_ack) acks++;
        if (trigger_victory) trigs++;
        if (r == 5 && c == 9) trig_last = trigger_victory;
      end
    end
    hit_valid = 1'b0;
    check({tag, "_acks"}, acks, exp_hits);
    check({tag, "_trig_count"}, trigs, 1);
    check({tag, "_trig_on_last"}, trig_last, 1);
    check({tag, "_bl_zero"}, bricks_left, 0);
  endtask

  initial begin
    int rr_seen;
    int tr_seen;

    vecs[0]  = '{1'b0, 3'd0, 4'd0,  10'd65, 9'd48,  1'b0, 6'd60, 1'b1};
    vecs[1]  = '{1'b0, 3'd0, 4'd0,  10'd64, 9'd48,  1'b0, 6'd60, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 4'd0,  10'd10, 9'd10,  1'b0, 6'd60, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 4'd3,  10'd197, 9'd80, 1'b1, 6'd59, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 4'd0,  10'd197, 9'd80, 1'b0, 6'd59, 1'b0};
    vecs[5]  = '{1'b1, 3'd2, 4'd3,  10'd10, 9'd10,  1'b0, 6'd59, 1'b0};
    vecs[6]  = '{1'b1, 3'd7, 4'd3,  10'd10, 9'd10,  1'b0, 6'd59, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 4'd10, 10'd10, 9'd10,  1'b0, 6'd59, 1'b0};
    vecs[8]  = '{1'b1, 3'd0, 4'd0,  10'd639, 9'd143, 1'b1, 6'd58, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 4'd0,  10'd640, 9'd48, 1'b0, 6'd58, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 4'd0,  10'd1,  9'd144, 1'b0, 6'd58, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 4'd0,  10'd1,  9'd48,  1'b0, 6'd58, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 4'd0,  10'd1,  9'd47,  1'b0, 6'd58, 1'b0};

    reset = 1'b1;
    hit_valid = 1'b0;
    hit_row = 3'd0;
    hit_col = 4'd0;
    victory_complete = 1'b0;
    pixel_x = 10'd65;
    pixel_y = 9'd48;
    step();
    step();
    check("rst_hit_ack", hit_ack, 0);
    check("rst_trigger", trigger_victory, 0);
    check("rst_round_reset", round_reset, 0);
    check("rst_bricks_left", bricks_left, 60);
    check("rst_brick_on", brick_on, 0);
`ifdef BRICK_SCORE_EN
    check("rst_score", score, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      hit_valid = vecs[i].hv;
      hit_row   = vecs[i].r;
      hit_col   = vecs[i].c;
      pixel_x   = vecs[i].px;
      pixel_y   = vecs[i].py;
      step();
      check($sformatf("vec%0d_ack", i), hit_ack, vecs[i].ack);
      check($sformatf("vec%0d_bl", i), bricks_left, vecs[i].bl);
      check($sformatf("vec%0d_on", i), brick_on, vecs[i].on);
    end
    hit_valid = 1'b0;
`ifdef BRICK_SCORE_EN
    check("score_after_table", score, 10);
`endif

    clear_field("round1", 58);
    step();
    check("trig_one_cycle", trigger_victory, 0);
    hit_valid = 1'b1;
    hit_row = 3'd1;
    hit_col = 4'd1;
    step();
    hit_valid = 1'b0;
    check("vw_hit_ack", hit_ack, 0);
    check("vw_bl", bricks_left, 0);

    rr_seen = 0;
    tr_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (round_reset) rr_seen++;
      if (trigger_victory) tr_seen++;
    end
    check("vw_hold_rr", rr_seen, 0);
    check("vw_hold_trig", tr_seen, 0);
    check("vw_hold_bl", bricks_left, 0);

    victory_complete = 1'b1;
    step();
    check("restore_rr", round_reset, 1);
    check("restore_bl_pre", bricks_left, 0);
    victory_complete = 1'b0;
    pixel_x = 10'd65;
    pixel_y = 9'd48;
    step();
    check("restore_rr_off", round_reset, 0);
    check("restore_bl", bricks_left, 60);
    step();
    check("restore_brick_on", brick_on, 1);
`ifdef BRICK_SCORE_EN
    check("score_round1", score, 210);
`endif

    victory_complete = 1'b1;
    clear_field("round2", 60);
    step();
    check("early_vc_rr", round_reset, 1);
    victory_complete = 1'b0;
    step();
    check("early_vc_bl", bricks_left, 60);
`ifdef BRICK_SCORE_EN
    check("score_round2", score, 420);
`endif

    clear_field("round3", 60);
    check("pre_async_ack", hit_ack, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_hit_ack", hit_ack, 0);
    check("async_trigger", trigger_victory, 0);
    check("async_rr", round_reset, 0);
    check("async_bl", bricks_left, 60);
    check("async_brick_on", brick_on, 0);
`ifdef BRICK_SCORE_EN
    check("async_score", score, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    hit_valid = 1'b1;
    hit_row = 3'd4;
    hit_col = 4'd9;
    step();
    hit_valid = 1'b0;
    check("post_reset_ack", hit_ack, 1);
    check("post_reset_bl", bricks_left, 59);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
